// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank.
// Holds the packed RGB type, the commit FSM state enum and the reset palette.
// No ports; imported by sprite_palette_bank and palette_sync_ctrl.
package sprite_palette_pkg;

  localparam int PAL_COLOR_W = 4;
  localparam int PAL_DEPTH   = 16;

  typedef struct packed {
    logic [PAL_COLOR_W-1:0] r;
    logic [PAL_COLOR_W-1:0] g;
    logic [PAL_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    SYNC = 1'b1
  } sync_state_t;

  // Power-up colours shared by every bank and both copies.
  localparam rgb_t DEFAULT_PALETTE [PAL_DEPTH] = '{
    12'hAEA, 12'h000, 12'hAEA, 12'hF76,
    12'h050, 12'hAEA, 12'hAEA, 12'hAEA,
    12'hAEA, 12'hAEA, 12'hAEA, 12'hAEA,
    12'hFFF, 12'hFFF, 12'hAEA, 12'hAEA
  };

endpackage

// File: rtl/palette_sync_ctrl.sv
// Write-accept / commit controller: tracks dirty banks, flips active copies at
// frame_start and sweeps active->shadow copies over the committed banks.
// Ports: Clk, Reset, frame_start, wr_req/wr_bank in; wr_ack, busy, commit,
// toggle_mask, copy_en/copy_bank/copy_index out.
module palette_sync_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W   = 4,
  parameter int NUM_BANKS = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         wr_req,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  output logic                         wr_ack,
  output logic                         busy,
  output logic                         commit,
  output logic [NUM_BANKS-1:0]         toggle_mask,
  output logic                         copy_en,
  output logic [$clog2(NUM_BANKS)-1:0] copy_bank,
  output logic [INDEX_W-1:0]           copy_index
);

  localparam int BW = $clog2(NUM_BANKS);

  sync_state_t          state_q, state_d;
  logic [NUM_BANKS-1:0] dirty_q, sync_mask_q;
  logic [BW-1:0]        bank_q, first_bank, nxt_bank;
  logic [INDEX_W-1:0]   entry_q;
  logic                 ack_q, nxt_found, last_entry;

  // ack_q blocks an accept on the cycle right after one, so a held wr_req
  // cannot be acked twice in a row.
  assign wr_ack      = !Reset && (state_q == IDLE) && wr_req && !frame_start && !ack_q;
  assign commit      = (state_q == IDLE) && frame_start;
  assign toggle_mask = dirty_q;
  assign busy        = (state_q == SYNC);
  assign copy_en     = (state_q == SYNC);
  assign copy_bank   = bank_q;
  assign copy_index  = entry_q;
  assign last_entry  = (entry_q == '1);

  // Lowest dirty bank starts the sweep; the next masked bank above the
  // current one continues it, so unmasked banks cost no cycles.
  always_comb begin
    first_bank = '0;
    nxt_bank   = '0;
    nxt_found  = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (dirty_q[i]) first_bank = BW'(i);
      if (sync_mask_q[i] && (i > int'(bank_q))) begin
        nxt_bank  = BW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_start && (|dirty_q)) state_d = SYNC;
      SYNC: if (last_entry && !nxt_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      dirty_q     <= '0;
      sync_mask_q <= '0;
      bank_q      <= '0;
      entry_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= wr_ack;
      if (wr_ack) dirty_q[wr_bank] <= 1'b1;
      if (commit) begin
        sync_mask_q <= dirty_q;
        dirty_q     <= '0;
        bank_q      <= first_bank;
        entry_q     <= '0;
      end
      if (state_q == SYNC) begin
        if (last_entry) begin
          entry_q <= '0;
          bank_q  <= nxt_bank;
        end else begin
          entry_q <= entry_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_palette_bank.sv
// Double-buffered multi-bank sprite palette: index+bank -> 12-bit RGB plus
// transparency. Lookup latency 1 (2 with PALETTE_FADE_EN, which adds
// fade_shift). Ports: Clk, Reset, frame_start, rd_* lookup in, out_valid/
// red/green/blue/out_transparent out, wr_* write handshake, busy.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W         = 4,
  parameter int COLOR_W         = PAL_COLOR_W,
  parameter int NUM_BANKS       = 4,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         rd_valid,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [INDEX_W-1:0]           rd_index,
`ifdef PALETTE_FADE_EN
  input  logic [1:0]                   fade_shift,
`endif
  output logic                         out_valid,
  output logic [COLOR_W-1:0]           red,
  output logic [COLOR_W-1:0]           green,
  output logic [COLOR_W-1:0]           blue,
  output logic                         out_transparent,
  input  logic                         wr_req,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [INDEX_W-1:0]           wr_index,
  input  logic [3*COLOR_W-1:0]         wr_data,
  output logic                         wr_ack,
  output logic                         busy
);

  localparam int BW   = $clog2(NUM_BANKS);
  localparam int NENT = 2 ** INDEX_W;
  localparam int CW3  = 3 * COLOR_W;

  logic [CW3-1:0]       mem [NUM_BANKS][2][NENT];
  logic [NUM_BANKS-1:0] sel;

  logic                 commit, copy_en;
  logic [NUM_BANKS-1:0] toggle_mask;
  logic [BW-1:0]        copy_bank;
  logic [INDEX_W-1:0]   copy_index;

  palette_sync_ctrl #(
    .INDEX_W   (INDEX_W),
    .NUM_BANKS (NUM_BANKS)
  ) u_ctrl (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .wr_req      (wr_req),
    .wr_bank     (wr_bank),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .commit      (commit),
    .toggle_mask (toggle_mask),
    .copy_en     (copy_en),
    .copy_bank   (copy_bank),
    .copy_index  (copy_index)
  );

  // Writes and sweep copies always target the shadow (~sel) copy; they are
  // mutually exclusive because writes are only accepted in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel <= '0;
      for (int b = 0; b < NUM_BANKS; b++)
        for (int c = 0; c < 2; c++)
          for (int e = 0; e < NENT; e++)
            mem[b][c][e] <= CW3'(DEFAULT_PALETTE[e % PAL_DEPTH]);
    end else begin
      if (commit) sel <= sel ^ toggle_mask;
      if (wr_ack) mem[wr_bank][~sel[wr_bank]][wr_index] <= wr_data;
      if (copy_en)
        mem[copy_bank][~sel[copy_bank]][copy_index] <= mem[copy_bank][sel[copy_bank]][copy_index];
    end
  end

  logic [CW3-1:0] look_q;
  logic           look_vld_q, look_tr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      look_q     <= '0;
      look_vld_q <= 1'b0;
      look_tr_q  <= 1'b0;
    end else begin
      look_vld_q <= rd_valid;
      if (rd_valid) begin
        look_q    <= mem[rd_bank][sel[rd_bank]][rd_index];
        look_tr_q <= (rd_index == INDEX_W'(TRANSPARENT_IDX));
      end
    end
  end

`ifdef PALETTE_FADE_EN
  logic [1:0]         shift_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               vld_q, tr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      if (rd_valid) shift_q <= fade_shift;
      vld_q <= look_vld_q;
      if (look_vld_q) begin
        r_q  <= look_q[CW3-1 -: COLOR_W] >> shift_q;
        g_q  <= look_q[2*COLOR_W-1 -: COLOR_W] >> shift_q;
        b_q  <= look_q[COLOR_W-1:0] >> shift_q;
        tr_q <= look_tr_q;
      end
    end
  end

  assign out_valid       = vld_q;
  assign red             = r_q;
  assign green           = g_q;
  assign blue            = b_q;
  assign out_transparent = tr_q;
`else
  assign out_valid       = look_vld_q;
  assign red             = look_q[CW3-1 -: COLOR_W];
  assign green           = look_q[2*COLOR_W-1 -: COLOR_W];
  assign blue            = look_q[COLOR_W-1:0];
  assign out_transparent = look_tr_q;
`endif

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Bench for sprite_palette_bank: randomized lookups/writes/commits checked
// against a committed-plus-pending palette model.
module tb_sprite_palette_bank;

  localparam int NB = 4;
  localparam int NE = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        rd_valid;
  logic [1:0]  rd_bank;
  logic [3:0]  rd_index;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        out_transparent;
  logic        wr_req;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        busy;
`ifdef PALETTE_FADE_EN
  localparam int LAT = 2;
  logic [1:0]  fade_shift;
`else
  localparam int LAT = 1;
`endif

  int total = 0;
  int bad   = 0;

  sprite_palette_bank dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_start     (frame_start),
    .rd_valid        (rd_valid),
    .rd_bank         (rd_bank),
    .rd_index        (rd_index),
`ifdef PALETTE_FADE_EN
    .fade_shift      (fade_shift),
`endif
    .out_valid       (out_valid),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .out_transparent (out_transparent),
    .wr_req          (wr_req),
    .wr_bank         (wr_bank),
    .wr_index        (wr_index),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .busy            (busy)
  );

  always #5 Clk = ~Clk;

  // Model: what lookups currently see, plus writes waiting for the next commit.
  logic [11:0] vis  [NB][NE];
  logic [11:0] pend [NB][NE];
  bit          pv   [NB][NE];

  function automatic logic [11:0] def_color(input int i);
    case (i)
      1:       return 12'h000;
      3:       return 12'hF76;
      4:       return 12'h050;
      12, 13:  return 12'hFFF;
      default: return 12'hAEA;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < NE; e++) begin
        vis[b][e] = def_color(e);
        pv[b][e]  = 1'b0;
      end
  endtask

  function automatic int dirty_banks();
    int n = 0;
    for (int b = 0; b < NB; b++) begin
      bit d = 1'b0;
      for (int e = 0; e < NE; e++) d |= pv[b][e];
      if (d) n++;
    end
    return n;
  endfunction

  task automatic model_commit();
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < NE; e++)
        if (pv[b][e]) begin
          vis[b][e] = pend[b][e];
          pv[b][e]  = 1'b0;
        end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lookup(input int b, input int i, input int sh, input string tag);
    logic [11:0] e;
    logic [11:0] expc;
    e    = vis[b][i];
    expc = {e[11:8] >> sh, e[7:4] >> sh, e[3:0] >> sh};
    rd_valid = 1'b1;
    rd_bank  = 2'(b);
    rd_index = 4'(i);
`ifdef PALETTE_FADE_EN
    fade_shift = 2'(sh);
`endif
    tick();
    rd_valid = 1'b0;
`ifdef PALETTE_FADE_EN
    tick();
`endif
    total++;
    if (out_valid !== 1'b1 || {red, green, blue} !== expc || out_transparent !== (i == 0)) begin
      bad++;
      $display("FAIL %s bank=%0d idx=%0d: got vld=%b rgb=%h tr=%b, want vld=1 rgb=%h tr=%b",
               tag, b, i, out_valid, {red, green, blue}, out_transparent, expc, (i == 0));
    end
  endtask

  task automatic do_write(input int b, input int i, input logic [11:0] d);
    int n = 0;
    wr_req = 1'b1; wr_bank = 2'(b); wr_index = 4'(i); wr_data = d;
    #1;
    while (!wr_ack && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL write_ack_timeout bank=%0d idx=%0d: ack=%b after %0d cycles, want 1", b, i, wr_ack, n);
    end else begin
      pend[b][i] = d;
      pv[b][i]   = 1'b1;
    end
    tick();
    wr_req = 1'b0;
  endtask

  task automatic commit_wait(input string tag);
    int exp_cyc;
    int cyc = 0;
    exp_cyc = 16 * dirty_banks();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_commit();
    while (busy && cyc < 300) begin
      cyc++;
      tick();
    end
    total++;
    if (cyc !== exp_cyc) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    rd_valid = 1'b1; rd_bank = 2'd2; rd_index = 4'd3;
    tick(); tick();
    rd_valid = 1'b0;
    Reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if ({red, green, blue} !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
    total++;
    if (out_transparent !== 1'b0) begin bad++; $display("FAIL reset_transparent: got %b want 0", out_transparent); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
  endtask

  task automatic test_defaults();
    logic [11:0] held;
    lookup(2, 0, 0, "default_b2_i0");
    lookup(2, 3, 0, "default_b2_i3");
    lookup(2, 4, 0, "default_b2_i4");
    held = {red, green, blue};
    tick();
    total++;
    if (out_valid !== 1'b0 || {red, green, blue} !== held) begin
      bad++;
      $display("FAIL hold_when_idle: got vld=%b rgb=%h want vld=0 rgb=%h", out_valid, {red, green, blue}, held);
    end
    for (int k = 0; k < 8; k++)
      lookup($urandom_range(0, NB - 1), $urandom_range(0, NE - 1), 0, "default_rand");
  endtask

  task automatic test_write_commit();
    do_write(1, 5, 12'h123);
    lookup(1, 5, 0, "before_commit");
    commit_wait("commit_b1");
    lookup(1, 5, 0, "after_commit");
  endtask

  task automatic test_sync_len();
    int cyc;
    bit acked_busy = 1'b0;
    do_write(0, 2, 12'h9C1);
    do_write(3, 14, 12'h3E7);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_commit();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sync_entry_busy: got %b want 1", busy); end
    lookup(0, 2, 0, "lookup_in_sync");
    cyc = LAT;
    wr_req = 1'b1; wr_bank = 2'd1; wr_index = 4'd9; wr_data = 12'h5A5;
    #1;
    while (busy && cyc < 300) begin
      if (wr_ack) acked_busy = 1'b1;
      cyc++;
      tick();
    end
    total++;
    if (cyc !== 32) begin bad++; $display("FAIL sync_two_banks_len: got %0d want 32", cyc); end
    total++;
    if (acked_busy) begin bad++; $display("FAIL ack_during_sync: got 1 want 0"); end
    total++;
    if (wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL ack_after_sync: got %b want 1", wr_ack);
    end else begin
      pend[1][9] = 12'h5A5;
      pv[1][9]   = 1'b1;
    end
    tick();
    wr_req = 1'b0;
    for (int e = 0; e < NE; e += 3) lookup(1, e, 0, "bank1_unchanged");
    lookup(3, 14, 0, "bank3_committed");
    commit_wait("commit_held");
    lookup(1, 9, 0, "held_write_committed");
  endtask

  task automatic test_collision();
    wr_req = 1'b1; wr_bank = 2'd2; wr_index = 4'd7; wr_data = 12'hB0D;
    frame_start = 1'b1;
    #1;
    total++;
    if (wr_ack !== 1'b0) begin bad++; $display("FAIL collide_ack: got %b want 0", wr_ack); end
    tick();
    frame_start = 1'b0;
    #1;
    total++;
    if (wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL collide_next_ack: got %b want 1", wr_ack);
    end else begin
      pend[2][7] = 12'hB0D;
      pv[2][7]   = 1'b1;
    end
    tick();
    wr_req = 1'b0;
    lookup(2, 7, 0, "collide_not_committed");
    commit_wait("collide_commit");
    lookup(2, 7, 0, "collide_committed");
  endtask

  task automatic test_back_to_back();
    wr_req = 1'b1; wr_bank = 2'd3; wr_index = 4'd7; wr_data = 12'h1F2;
    #1;
    total++;
    if (wr_ack !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b want 1", wr_ack); end
    else begin pend[3][7] = 12'h1F2; pv[3][7] = 1'b1; end
    tick();
    wr_index = 4'd8; wr_data = 12'h2E3;
    #1;
    total++;
    if (wr_ack !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", wr_ack); end
    tick();
    total++;
    if (wr_ack !== 1'b1) begin bad++; $display("FAIL b2b_second: got %b want 1", wr_ack); end
    else begin pend[3][8] = 12'h2E3; pv[3][8] = 1'b1; end
    tick();
    do_write(3, 8, 12'h4C4);
    wr_req = 1'b0;
    commit_wait("b2b_commit");
    lookup(3, 7, 0, "b2b_idx7");
    lookup(3, 8, 0, "b2b_last_wins");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) begin
`ifdef PALETTE_FADE_EN
        lookup($urandom_range(0, NB - 1), $urandom_range(0, NE - 1), $urandom_range(0, 3), "rand_lookup");
`else
        lookup($urandom_range(0, NB - 1), $urandom_range(0, NE - 1), 0, "rand_lookup");
`endif
      end else if (r < 9) begin
        do_write($urandom_range(0, NB - 1), $urandom_range(0, NE - 1), 12'($urandom));
      end else begin
        commit_wait("rand_commit");
      end
    end
    commit_wait("rand_final_commit");
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < NE; e += 5) lookup(b, e, 0, "rand_sweep");
  endtask

  task automatic test_reset_mid_sync();
    do_write(2, 3, 12'h111);
    commit_wait("pre_reset_commit");
    lookup(2, 3, 0, "pre_reset_value");
    do_write(0, 1, 12'h222);
    do_write(1, 4, 12'h333);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rd_valid = 1'b1; rd_bank = 2'd0; rd_index = 4'd1;
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    rd_valid = 1'b0;
    model_reset();
    total++;
    if (out_valid !== 1'b0 || {red, green, blue} !== 12'h000 || out_transparent !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_sync_reset_outputs: got vld=%b rgb=%h tr=%b busy=%b want all 0",
               out_valid, {red, green, blue}, out_transparent, busy);
    end
    commit_wait("post_reset_no_dirty");
    lookup(2, 3, 0, "post_reset_default");
    lookup(0, 1, 0, "post_reset_b0");
    lookup(1, 4, 0, "post_reset_b1");
  endtask

`ifdef PALETTE_FADE_EN
  task automatic test_fade();
    lookup(2, 3, 1, "fade_shift1");
    total++;
    if ({red, green, blue} !== 12'h733) begin bad++; $display("FAIL fade_f76: got %h want 733", {red, green, blue}); end
    lookup(0, 12, 3, "fade_shift3");
  endtask
`endif

  initial begin
    Reset = 1'b1; frame_start = 1'b0; rd_valid = 1'b0; rd_bank = '0; rd_index = '0;
    wr_req = 1'b0; wr_bank = '0; wr_index = '0; wr_data = '0;
`ifdef PALETTE_FADE_EN
    fade_shift = '0;
`endif
    test_reset();
    test_defaults();
`ifdef PALETTE_FADE_EN
    test_fade();
`endif
    test_write_commit();
    test_sync_len();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
